// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-stage access controller.
// No logic here: state encoding, load marker and default widths.
// Imported by mem_access_unit and mem_watchdog.
package mem_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // ResultSrc encoding that selects memory read data in writeback (a load)
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A stage carries a memory access when it stores or loads
  function automatic logic is_access(input logic mem_write, input logic [1:0] result_src);
    return mem_write | (result_src == RESULT_SRC_MEM);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog for the data-memory port (built only with MEM_TIMEOUT_EN).
// Latency: expired is combinational in the TIMEOUT_CYCLES-th busy cycle.
// Backpressure: none; ready in the limit cycle suppresses expiry.
module mem_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // count holds the number of busy cycles already completed in this access
  logic [CNT_W-1:0] count;

  // Clear on entry to BUSY, advance once per busy cycle, saturate at the limit
  always_ff @(posedge clock) begin
    if (reset || start) begin
      count <= '0;
    end else if (busy && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = busy & ~ready & (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access controller: registered req/ready port, StallM hold.
// Latency: 2 cycles minimum (IDLE+BUSY stalled, DONE releases), +1 per wait cycle.
// Backpressure: StallM holds upstream while dmem_ready is low; MEM_TIMEOUT_EN adds abort.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              BusErrorM
);

  state_t state, next_state;
  logic   access;
  logic   expired;

  assign access = is_access(MemWriteM, ResultSrcM);

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .start  ((state == IDLE) && access),
    .busy   (state == BUSY),
    .ready  (dmem_ready),
    .expired(expired)
  );

  // Error flag is high only in the DONE cycle that follows an aborted access
  always_ff @(posedge clock) begin
    if (reset) begin
      BusErrorM <= 1'b0;
    end else begin
      BusErrorM <= expired && (next_state == DONE);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expired            = 1'b0;
  assign BusErrorM          = 1'b0;
`endif

  // Next-state and stall: stall from the cycle the access appears until BUSY ends
  always_comb begin
    next_state = state;
    StallM     = 1'b0;
    case (state)
      IDLE: begin
        StallM = access;
        if (access) next_state = BUSY;
      end
      BUSY: begin
        StallM = 1'b1;
        if (dmem_ready || expired) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, registered port fields and load-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ReadDataM  <= '0;
    end else begin
      state    <= next_state;
      dmem_req <= (next_state == BUSY);
      case (state)
        IDLE: begin
          if (access) begin
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
            dmem_wdata <= WriteDataM;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            if (!dmem_we) ReadDataM <= dmem_rdata;
          end else if (expired) begin
            ReadDataM <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboard queue + memory responder.
// Stimulus issues M-stage instructions as a stalled pipeline would present them.
// Monitor checks each request, the DONE cycle and the stall length independently.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  wire         dmem_ready;
  wire  [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrorM;

  mem_access_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .BusErrorM(BusErrorM)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [7:0]  stall;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   dly_q[$];

  // reference memory (stimulus side) and device memory (responder side)
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dev_mem[logic [31:0]];
  logic [31:0] last_rd = 32'h0;

  logic        mon_en  = 1'b0;
  logic        resp_en = 1'b1;
  logic        r_ready = 1'b0;
  logic [31:0] r_rdata = 32'h0;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  assign dmem_ready = resp_en ? r_ready : man_ready;
  assign dmem_rdata = resp_en ? r_rdata : man_rdata;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one memory instruction, hold it while stalled, return at its DONE cycle
  task automatic issue(input logic we, input logic [1:0] rs, input logic [31:0] a,
                       input logic [31:0] d, input int dly);
    exp_t        e;
    logic [31:0] wa;
    int          n;
    wa = {a[31:2], 2'b00};
    @(posedge clock); #1;
    e.we    = we;
    e.addr  = wa;
    e.wdata = d;
    e.stall = 8'(2 + dly);
    if (we) begin
      e.rd        = last_rd;
      ref_mem[wa] = d;
    end else begin
      e.rd    = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
      last_rd = e.rd;
    end
    exp_q.push_back(e);
    dly_q.push_back(dly);
    MemWriteM  = we;
    ResultSrcM = rs;
    ALUResultM = a;
    WriteDataM = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (StallM && n < 100);
    if (n >= 100) begin
      errors++;
      $display("FAIL stall_timeout: StallM still %b after %0d cycles", StallM, n);
    end
  endtask

  task automatic nonmem(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(2, 3));
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      @(negedge clock);
    end
  endtask

  // Memory responder: per-request delay from the queue, random ready when idle
  initial begin : responder
    int cnt;
    bit active;
    active = 1'b0;
    cnt    = 0;
    forever begin
      @(posedge clock); #1;
      if (resp_en && dmem_req) begin
        if (!active) begin
          cnt    = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          active = 1'b1;
        end
        if (cnt == 0) begin
          r_ready = 1'b1;
          if (dmem_we) begin
            dev_mem[dmem_addr] = dmem_wdata;
            r_rdata = $urandom;
          end else begin
            r_rdata = dev_mem.exists(dmem_addr) ? dev_mem[dmem_addr] : init_word(dmem_addr);
          end
          active = 1'b0;
        end else begin
          r_ready = 1'b0;
          r_rdata = $urandom;
          cnt--;
        end
      end else begin
        r_ready = 1'($urandom_range(0, 1));
        r_rdata = $urandom;
        active  = 1'b0;
      end
    end
  end

  // Monitor: compares each presented request and the following DONE cycle
  initial begin : monitor
    exp_t e;
    exp_t cur;
    bit   pend_done;
    int   stall_run;
    pend_done = 1'b0;
    stall_run = 0;
    cur       = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (StallM) stall_run++;
        if (pend_done) begin
          chk("done_rdata", ReadDataM, cur.rd);
          chk("done_stall_low", 32'(StallM), 32'd0);
          chk("done_req_low", 32'(dmem_req), 32'd0);
          chk("done_buserr", 32'(BusErrorM), 32'd0);
          chk("stall_cycles", 32'(stall_run), 32'(cur.stall));
          pend_done = 1'b0;
          stall_run = 0;
        end else if (dmem_req) begin
          if (exp_q.size() == 0) begin
            chk("spurious_req", 32'(dmem_req), 32'd0);
          end else begin
            e = exp_q[0];
            chk("req_we", 32'(dmem_we), 32'(e.we));
            chk("req_addr", dmem_addr, e.addr);
            if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
            if (dmem_ready) begin
              cur       = exp_q.pop_front();
              pend_done = 1'b1;
            end
          end
        end else if (exp_q.size() == 0) begin
          chk("idle_stall", 32'(StallM), 32'd0);
        end
      end
    end
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          r;
    logic        we;
    logic [1:0]  rs;
    int          n;
    int          stalls;
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_buserr", 32'(BusErrorM), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // directed: load 0x100 no wait, store 0x207 three waits, back-to-back pair
    issue(1'b0, 2'b01, 32'h0000_0100, 32'h0, 0);
    issue(1'b1, 2'b00, 32'h0000_0207, 32'h1234_5678, 3);
    issue(1'b0, 2'b01, 32'h0000_0204, 32'h0, 1);
    issue(1'b1, 2'b01, 32'h0000_0100, 32'hCAFE_F00D, 0);
    nonmem(4);
    issue(1'b0, 2'b01, 32'h0000_0100, 32'h0, 2);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        nonmem($urandom_range(1, 3));
      end else begin
        we = (r >= 6);
        rs = we ? 2'($urandom_range(0, 3)) : 2'b01;
        issue(we, rs, 32'h1000 + $urandom_range(0, 63), $urandom, $urandom_range(0, 4));
      end
    end
    issue(1'b1, 2'b00, 32'h0000_0300, 32'h0BAD_CAFE, 1);
    issue(1'b0, 2'b01, 32'h0000_0301, 32'h0, 0);
    nonmem(2);

`ifdef MEM_TIMEOUT_EN
    // watchdog abort with ready held low
    mon_en    = 1'b0;
    resp_en   = 1'b0;
    man_ready = 1'b0;
    @(posedge clock); #1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h88;
    n      = 0;
    stalls = 0;
    do begin
      @(negedge clock);
      n++;
      if (StallM) stalls++;
    end while (!BusErrorM && n < 50);
    chk("tmo_buserr", 32'(BusErrorM), 32'd1);
    chk("tmo_rdata", ReadDataM, 32'h0);
    chk("tmo_stall_len", 32'(stalls), 32'(1 + TMO));
    chk("tmo_stall_low", 32'(StallM), 32'd0);
    @(posedge clock); #1;
    ResultSrcM = 2'b00;
    @(negedge clock);
    chk("tmo_err_pulse", 32'(BusErrorM), 32'd0);
    last_rd = 32'h0;
    resp_en = 1'b1;
    mon_en  = 1'b1;
    issue(1'b0, 2'b01, 32'h0000_0100, 32'h0, 0);
`endif

    // reset in the second BUSY cycle, with ready high in that same cycle
    mon_en    = 1'b0;
    resp_en   = 1'b0;
    man_ready = 1'b0;
    @(posedge clock); #1;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h0000_0044;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset     = 1'b1;
    man_ready = 1'b1;
    man_rdata = 32'hFFFF_0000;
    @(negedge clock);
    chk("busy2_req", 32'(dmem_req), 32'd1);
    @(posedge clock); #1;
    reset      = 1'b0;
    ResultSrcM = 2'b00;
    @(negedge clock);
    chk("post_rst_req", 32'(dmem_req), 32'd0);
    chk("post_rst_rdata", ReadDataM, 32'h0);
    chk("post_rst_stall", 32'(StallM), 32'd0);
    chk("post_rst_buserr", 32'(BusErrorM), 32'd0);
    @(posedge clock); #1;
    man_ready = 1'b0;
    @(negedge clock);
    chk("post_rst_idle_req", 32'(dmem_req), 32'd0);
    chk("post_rst_hold", ReadDataM, 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB register. It turns the M-stage control and data (MemWriteM, ResultSrcM, ALUResultM, WriteDataM) into a registered request/ready transaction on the data-memory port. It returns load data as ReadDataM and holds the pipeline with StallM until the transaction completes. StallM drives the hazard unit, which deasserts `enable` on EX/MEM and all earlier stage registers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with MEM_TIMEOUT_EN

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- MemWriteM  in  1  store in M stage
- ResultSrcM  in  2  2'b01 marks a load
- ALUResultM  in  ADDR_W  effective address
- WriteDataM  in  DATA_W  store data
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  1 = write, 0 = read (registered)
- dmem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00} (registered)
- dmem_wdata  out  DATA_W  store data (registered)
- dmem_ready  in  1  memory completes the current request this cycle
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1 on a read
- ReadDataM  out  DATA_W  load result to MEM/WB
- StallM  out  1  hold upstream registers
- BusErrorM  out  1  access aborted by watchdog

## Operation
- access = MemWriteM | (ResultSrcM == 2'b01). A pending access is never both a load and a store; MemWriteM takes precedence.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if access, latch address, data and we, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: dmem_req=1, with addr/we/wdata held stable. If dmem_ready=1, capture dmem_rdata into ReadDataM (reads only) and go to DONE.
  - DONE: dmem_req=0. Go to IDLE unconditionally.
- StallM (combinational) = (IDLE & access) | BUSY. It is 0 in DONE, so the instruction advances at the end of the DONE cycle.
- DONE→IDLE is unconditional, so a back-to-back access is seen in IDLE one cycle later. No access is issued twice.
- ReadDataM holds its value until the next read completes. Stores leave ReadDataM unchanged.
- dmem_addr[1:0] is always 0. Byte and half accesses are out of scope.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, ReadDataM=0, BusErrorM=0. StallM follows its equation (0 if no access is present).
- Reset mid-transaction: the FSM returns to IDLE at that edge and dmem_req drops. Memory must treat a dropped req as an abandoned request.

## Timing
- Access presented in cycle N: StallM=1 in N.
- dmem_req=1 from N+1.
- If dmem_ready=1 in N+1: DONE in N+2, StallM=0 in N+2, ReadDataM valid in N+2. Minimum stall is 2 cycles.
- Each extra wait cycle (dmem_ready=0 in BUSY) adds one stall cycle.
- dmem_ready is ignored outside BUSY.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without dmem_ready, go to DONE with ReadDataM=0 and BusErrorM=1 for the DONE cycle only.
  - dmem_ready in the same cycle as the limit wins: normal completion, no error.
- Not defined: BUSY waits indefinitely and BusErrorM is tied to 0.

## Structure
- Package mem_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - RESULT_SRC_MEM = 2'b01
  - default widths
- Optional sub-module mem_watchdog, instantiated only under MEM_TIMEOUT_EN.
  - Inputs: clock, reset, start, busy, ready.
  - Output: expired.

## Test plan
- Load, ALUResultM=0x0000_0100, dmem_ready=1 in first BUSY cycle, dmem_rdata=0xDEAD_BEEF:
  - StallM=1 for 2 cycles.
  - dmem_addr=0x100, dmem_we=0.
  - ReadDataM=0xDEADBEEF in DONE.
- Store to 0x0000_0207 with WriteDataM=0x1234_5678, ready delayed 3 cycles:
  - dmem_addr=0x204, dmem_we=1, wdata stable for all 4 BUSY cycles.
  - StallM=1 for 5 cycles.
  - ReadDataM unchanged.
- Back-to-back load then store:
  - Two distinct requests separated by DONE+IDLE.
  - dmem_req is low in the DONE cycle between them.
- Reset asserted in the second BUSY cycle:
  - Next cycle state=IDLE, dmem_req=0, ReadDataM=0.
  - No capture even if dmem_ready=1 in the reset cycle.
- Non-memory instruction (ResultSrcM=2'b00, MemWriteM=0): StallM=0 and dmem_req=0 throughout.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and dmem_ready held at 0:
  - BusErrorM=1 for exactly one cycle with ReadDataM=0.
  - StallM then drops.
